// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable clock-waveform controller.
// Generates a registered divided clock (clk_out) with programmable period,
// high time and start-up phase delay, plus rise/fall strobes. New settings
// arrive over a valid/ready handshake and only take effect at a period
// boundary, so the output never produces a runt pulse.
module clk_div_ctrl #(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned DEF_PERIOD = 4,
   parameter int unsigned DEF_HIGH   = 2,
   parameter int unsigned DEF_PHASE  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_high,
   input  logic [CNT_W-1:0] cfg_phase,
   output logic             cfg_err,
   output logic             clk_out,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PHASE = 2'd1,
      RUN   = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] ph_cnt;
   logic [CNT_W-1:0] act_period;
   logic [CNT_W-1:0] act_high;
   logic [CNT_W-1:0] act_phase;
   logic [CNT_W-1:0] pend_period;
   logic [CNT_W-1:0] pend_high;
   logic [CNT_W-1:0] pend_phase;
   logic             pend_valid;

   logic             accept;
   logic             cfg_ok;
   logic             take_new;
   logic             boundary;
   logic [CNT_W-1:0] nxt_period;
   logic [CNT_W-1:0] nxt_high;
   logic [CNT_W-1:0] nxt_phase;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] high_start;

   // A held config blocks further requests until it has been applied.
   assign cfg_ready = ~pend_valid;
   assign busy      = (state != IDLE);

   // Handshake decode, config validation, and the config that a boundary
   // would put in force (held config first, otherwise one arriving this cycle).
   always_comb begin
      accept   = cfg_valid && !pend_valid;
      cfg_ok   = (cfg_period >= CNT_W'(2)) &&
                 (cfg_high != '0) &&
                 (cfg_high < cfg_period) &&
                 (cfg_phase < cfg_period);
      take_new = accept && cfg_ok;

      nxt_period = act_period;
      nxt_high   = act_high;
      nxt_phase  = act_phase;
      if (pend_valid) begin
         nxt_period = pend_period;
         nxt_high   = pend_high;
         nxt_phase  = pend_phase;
      end else if (take_new) begin
         nxt_period = cfg_period;
         nxt_high   = cfg_high;
         nxt_phase  = cfg_phase;
      end

      boundary = 1'b1;
      case (state)
         IDLE:    boundary = 1'b1;
         PHASE:   boundary = !enable || (ph_cnt == act_phase - CNT_W'(1));
         RUN:     boundary = (cnt == act_period - CNT_W'(1));
         default: boundary = 1'b1;
      endcase

      cnt_inc    = cnt + CNT_W'(1);
      high_start = act_period - act_high;
   end

   // Main controller: config bookkeeping, state machine, counters and the
   // registered waveform/strobe outputs all advance together on each edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         ph_cnt      <= '0;
         act_period  <= CNT_W'(DEF_PERIOD);
         act_high    <= CNT_W'(DEF_HIGH);
         act_phase   <= CNT_W'(DEF_PHASE);
         pend_period <= '0;
         pend_high   <= '0;
         pend_phase  <= '0;
         pend_valid  <= 1'b0;
         cfg_err     <= 1'b0;
         clk_out     <= 1'b0;
         rise_pulse  <= 1'b0;
         fall_pulse  <= 1'b0;
      end else begin
         cfg_err    <= accept && !cfg_ok;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;

         if (boundary) begin
            act_period <= nxt_period;
            act_high   <= nxt_high;
            act_phase  <= nxt_phase;
            pend_valid <= 1'b0;
         end else if (take_new) begin
            pend_period <= cfg_period;
            pend_high   <= cfg_high;
            pend_phase  <= cfg_phase;
            pend_valid  <= 1'b1;
         end

         case (state)
            IDLE: begin
               clk_out <= 1'b0;
               if (enable) begin
                  if (nxt_phase != '0) begin
                     state  <= PHASE;
                     ph_cnt <= '0;
                  end else begin
                     state <= RUN;
                     cnt   <= '0;
                  end
               end
            end
            PHASE: begin
               clk_out <= 1'b0;
               if (!enable) begin
                  state <= IDLE;
               end else if (ph_cnt == act_phase - CNT_W'(1)) begin
                  state <= RUN;
                  cnt   <= '0;
               end else begin
                  ph_cnt <= ph_cnt + CNT_W'(1);
               end
            end
            RUN: begin
               if (cnt == act_period - CNT_W'(1)) begin
                  cnt        <= '0;
                  clk_out    <= 1'b0;
                  fall_pulse <= clk_out;
                  if (!enable) begin
                     state <= IDLE;
                  end
               end else begin
                  cnt        <= cnt_inc;
                  clk_out    <= (cnt_inc >= high_start);
                  rise_pulse <= (cnt_inc == high_start);
               end
            end
            default: begin
               state   <= IDLE;
               clk_out <= 1'b0;
            end
         endcase
      end
   end

endmodule
